bmp_pix_writer: RTL and testbench
=================================

BMP_PIX_WRITER -- requirements
Module: bmp_pix_writer

Interface
REQ-001 Parameter: ADDR_W, default 20, width of pixel write address.
REQ-002 Parameter: FIFO_DEPTH, default 4, pixel write FIFO entries (power of two).
REQ-003 Port: Clk  in  1  the only clock; all logic rising-edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset.
REQ-005 Port: pixin  in  24  command word from NIOS bmp_pixout PIO export. Fields:
- [23] toggle flag
- [22:21] opcode
- [20:0] payload
REQ-006 Port: pix_ack  out  1  equals toggle flag of the last consumed command.
REQ-007 Port: wr_addr  out  ADDR_W  frame-buffer write address.
REQ-008 Port: wr_data  out  16  RGB565 pixel data.
REQ-009 Port: wr_req  out  1  write request.
REQ-010 Port: wr_ready  in  1  frame-buffer accepts write when high with wr_req.
REQ-011 Port: frame_done  out  1  one-cycle pulse, frame fully written.
REQ-012 Port: busy  out  1  high when FIFO non-empty, a command is pending, or state != IDLE.
REQ-013 Port: proto_err  out  1  sticky protocol error flag.

Function
REQ-014 pixin shall be registered once (cmd_q); a new command exists when cmd_q[23] != tog_q.
REQ-015 Opcode 00 SET_ADDR shall load addr_ptr <= payload[ADDR_W-1:0]; no FIFO entry.
REQ-016 Opcode 01 PIXEL shall push {addr_ptr, payload[15:0]} and increment addr_ptr modulo 2^ADDR_W; all-ones wraps to 0.
REQ-017 Opcode 10 FRAME_END shall enter DRAIN.
REQ-018 Opcode 11 is reserved: consumed and acked, no other effect.
REQ-019 Consuming a command shall set tog_q and pix_ack to cmd_q[23] at the same edge.
- Consume latency: 2 edges after a pixin change when not stalled.
REQ-020 States:
- IDLE: consume commands.
- STALL: PIXEL pending, FIFO count == FIFO_DEPTH; push and ack at the first edge where count < FIFO_DEPTH.
- DRAIN: no commands consumed; frame_done pulses the cycle after FIFO empty and no write outstanding, then IDLE.
REQ-021 Push shall require registered count < FIFO_DEPTH; a same-cycle pop does not free space for a push.
REQ-022 wr_req shall be high whenever the FIFO is non-empty, presenting the head entry; earliest rise is the cycle after the push.
REQ-023 Pop shall occur on wr_req && wr_ready; wr_addr/wr_data shall hold stable while wr_req && !wr_ready.
REQ-024 Simultaneous push and pop at count < FIFO_DEPTH shall leave count unchanged with order preserved.
REQ-025 proto_err shall set when pixin[23] changes while a command is already unconsumed (STALL, DRAIN, or unconsumed cmd_q); the newer word overwrites cmd_q.
REQ-026 Writes shall be emitted in push order; addresses carried per entry, so SET_ADDR never reorders queued pixels.

Reset
REQ-027 Reset high at an edge shall force:
- pix_ack=0, tog_q=0, cmd_q=0, addr_ptr=0
- FIFO empty, state IDLE
- wr_req=0, frame_done=0, busy=0, proto_err=0
REQ-028 Reset mid-write shall drop wr_req the next cycle and discard queued entries without completing them.
REQ-029 Output registers shall reach reset values one edge after Reset is sampled high.

Verification
REQ-030 Sequence and ack timing:
- Stimulus: SET_ADDR 0x00100 (tog 1), then PIXEL 0xF800 (tog 0), wr_ready=1.
- Response: pix_ack 1 then 0, each 2 edges after its pixin change; one write addr 0x00100 data 0xF800; addr_ptr 0x00101.
REQ-031 Backpressure and stall:
- Stimulus: 6 PIXELs with wr_ready=0.
- Response: 4 acked, 5th unacked (STALL), wr_addr/wr_data held; after wr_ready=1 all 6 written in order; 5th acked the edge after count drops below 4.
REQ-032 Address wrap:
- Stimulus: SET_ADDR 0xFFFFF, 2 PIXELs.
- Response: writes to 0xFFFFF then 0x00000.
REQ-033 Frame drain:
- Stimulus: 3 PIXELs then FRAME_END, wr_ready toggled 1/0.
- Response: frame_done exactly one pulse, the cycle after the 3rd write accepted; a command issued in DRAIN is not acked before frame_done.
REQ-034 Protocol error:
- Stimulus: two pixin toggles while in STALL.
- Response: proto_err=1, sticky until Reset.
REQ-035 Reset mid-operation:
- Stimulus: Reset asserted with 3 queued entries.
- Response: wr_req=0, busy=0, pix_ack=0; no further writes.

Source files
------------

// File: rtl/bmp_pix_writer.sv
// rtl/bmp_pix_writer.sv - NIOS PIO pixel command decoder with buffered frame-buffer writes
module bmp_pix_writer #(
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [23:0]       pixin,
  output logic              pix_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_req,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              busy,
  output logic              proto_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_W + 16;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OP_SET_ADDR  = 2'b00;
  localparam logic [1:0] OP_PIXEL     = 2'b01;
  localparam logic [1:0] OP_FRAME_END = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [23:0]       r_cmd_q;
  logic              r_tog_q;
  logic              r_pix_ack;
  logic              r_frame_done;
  logic              r_proto_err;
  logic [ADDR_W-1:0] r_addr_ptr;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic       w_pending;
  logic [1:0] w_opcode;
  logic       w_has_space;
  logic       w_pop;
  logic       w_push;
  logic       w_consume;
  logic       w_tog_change;
  logic       w_unused_bits;

  // A command is outstanding while the registered toggle differs from the last consumed one
  assign w_pending    = (r_cmd_q[23] != r_tog_q);
  assign w_opcode     = r_cmd_q[22:21];
  // Space is judged on the registered count only, so a same-cycle pop never makes room
  assign w_has_space  = (r_count < DEPTH_C);
  assign w_pop        = (r_count != '0) && wr_ready;
  assign w_tog_change = (pixin[23] != r_cmd_q[23]);
  assign w_unused_bits = r_cmd_q[20];

  // Decide whether the pending command is consumed and/or pushed this cycle
  always_comb begin
    w_push    = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          if (w_opcode == OP_PIXEL) begin
            if (w_has_space) begin
              w_push    = 1'b1;
              w_consume = 1'b1;
            end
          end else begin
            w_consume = 1'b1;
          end
        end
      end
      ST_STALL: begin
        // If the stalled word was overwritten by a non-pixel, IDLE handles it next cycle
        if (w_has_space && w_pending && (w_opcode == OP_PIXEL)) begin
          w_push    = 1'b1;
          w_consume = 1'b1;
        end
      end
      default: begin
        w_push    = 1'b0;
        w_consume = 1'b0;
      end
    endcase
  end

  // Command register, handshake toggle, address pointer and control state machine
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_cmd_q      <= '0;
      r_tog_q      <= 1'b0;
      r_pix_ack    <= 1'b0;
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
      r_addr_ptr   <= '0;
    end else begin
      r_cmd_q      <= pixin;
      r_frame_done <= 1'b0;

      // A new toggle landing on top of an unconsumed command (or while not accepting) is sticky
      if (w_tog_change && (w_pending || (r_state != ST_IDLE)) && !w_consume) begin
        r_proto_err <= 1'b1;
      end

      if (w_consume) begin
        r_tog_q   <= r_cmd_q[23];
        r_pix_ack <= r_cmd_q[23];
      end

      if (w_push) begin
        r_addr_ptr <= r_addr_ptr + ADDR_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            case (w_opcode)
              OP_SET_ADDR:  r_addr_ptr <= r_cmd_q[ADDR_W-1:0];
              OP_PIXEL:     if (!w_has_space) r_state <= ST_STALL;
              OP_FRAME_END: r_state <= ST_DRAIN;
              default:      r_state <= ST_IDLE;
            endcase
          end
        end
        ST_STALL: begin
          if (w_has_space) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // Pulse as soon as the FIFO is (or is becoming) empty; no pushes occur in DRAIN
          if ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage; each entry carries its own address so SET_ADDR cannot reorder pixels
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_addr_ptr, r_cmd_q[15:0]};
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pix_ack    = r_pix_ack;
  assign frame_done = r_frame_done;
  assign proto_err  = r_proto_err;
  assign wr_req     = (r_count != '0);
  assign wr_addr    = r_mem[r_rd_ptr][ENT_W-1:16];
  assign wr_data    = r_mem[r_rd_ptr][15:0];
  assign busy       = (r_count != '0) || w_pending || (r_state != ST_IDLE);

endmodule

// File: tb/tb_bmp_pix_writer.sv
// tb/tb_bmp_pix_writer.sv - scoreboard bench for bmp_pix_writer
module tb_bmp_pix_writer;
  localparam int AW = 20;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [23:0]   pixin = '0;
  logic          wr_ready = 1'b0;
  logic          pix_ack;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_req;
  logic          frame_done;
  logic          busy;
  logic          proto_err;

  bmp_pix_writer #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .pixin(pixin), .pix_ack(pix_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ready(wr_ready),
    .frame_done(frame_done), .busy(busy), .proto_err(proto_err)
  );

  initial forever #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic tog = 1'b0;
  logic [AW-1:0] model_addr = '0;
  logic [AW+15:0] exp_q[$];
  int writes_seen = 0;
  int last_acc_cyc = -1;
  int fd_count = 0;
  int fd_cyc = -1;
  int rdy_mode = 0;
  logic hold_prev = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [15:0] hold_data = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Monitor: scoreboard pop on every accepted write, hold-stability and frame_done tracking
  initial forever begin
    logic [AW+15:0] e;
    @(negedge Clk);
    if (Reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_wr_req", wr_req, 1);
        chk("hold_wr_addr", wr_addr, hold_addr);
        chk("hold_wr_data", wr_data, hold_data);
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (wr_req && wr_ready) begin
        writes_seen++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h/%0h expected=none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[AW+15:16]);
          chk("wr_data", wr_data, e[15:0]);
        end
      end
      hold_prev = wr_req && !wr_ready;
      hold_addr = wr_addr;
      hold_data = wr_data;
    end
  end

  // wr_ready driver: 0 = manual, 1 = random, 2 = alternate every cycle
  initial forever begin
    @(posedge Clk);
    #1;
    if (rdy_mode == 1) wr_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) wr_ready = ~wr_ready;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    pixin = '0;
    tog = 1'b0;
    tick(1);
    Reset = 1'b0;
    exp_q.delete();
    model_addr = '0;
  endtask

  // Issue one command and record the write it should eventually produce
  task automatic issue(input logic [1:0] op, input logic [20:0] pl);
    tog = ~tog;
    pixin = {tog, op, pl};
    if (op == 2'b00) begin
      model_addr = pl[AW-1:0];
    end else if (op == 2'b01) begin
      exp_q.push_back({model_addr, pl[15:0]});
      model_addr = model_addr + AW'(1);
    end
  endtask

  task automatic wait_ack(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge Clk);
      #1;
      if (pix_ack == tog) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      tick(1);
      n++;
    end
    chk(nm, (exp_q.size() == 0) && !busy, 1);
  endtask

  initial begin
    int lat;
    int ack_cyc;
    int ws;
    int r;
    logic [1:0] op;

    tick(2);
    do_reset();
    chk("rst_pix_ack", pix_ack, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);

    // Basic sequence and ack timing
    wr_ready = 1'b1;
    issue(2'b00, 21'h00100);
    wait_ack(6, lat);
    chk("seq_setaddr_latency", lat, 2);
    chk("seq_ack_one", pix_ack, 1);
    issue(2'b01, 21'h0F800);
    wait_ack(6, lat);
    chk("seq_pixel_latency", lat, 2);
    chk("seq_ack_zero", pix_ack, 0);
    issue(2'b01, 21'h01234);
    wait_ack(6, lat);
    wait_idle("seq_drained", 20);

    // Backpressure and stall
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(2'b01, 21'($urandom_range(0, 65535)));
      wait_ack(6, lat);
      chk("fill_ack_latency", lat, 2);
    end
    issue(2'b01, 21'($urandom_range(0, 65535)));
    wait_ack(6, lat);
    chk("stall_no_ack", lat > 0, 0);
    chk("stall_busy", busy, 1);
    chk("stall_wr_req", wr_req, 1);
    wr_ready = 1'b1;
    wait_ack(6, lat);
    chk("stall_release_latency", lat, 2);
    issue(2'b01, 21'($urandom_range(0, 65535)));
    wait_ack(6, lat);
    chk("sixth_ack_latency", lat, 2);
    wait_idle("stall_drained", 30);

    // Address wrap
    issue(2'b00, 21'h0FFFFF);
    wait_ack(6, lat);
    issue(2'b01, 21'h0001F);
    wait_ack(6, lat);
    issue(2'b01, 21'h007E0);
    wait_ack(6, lat);
    chk("wrap_ack", lat, 2);
    wait_idle("wrap_drained", 20);

    // Frame drain
    wr_ready = 1'b0;
    fd_count = 0;
    for (int i = 0; i < 3; i++) begin
      issue(2'b01, 21'($urandom_range(0, 65535)));
      wait_ack(6, lat);
    end
    issue(2'b10, 21'h0);
    wait_ack(6, lat);
    chk("frame_end_latency", lat, 2);
    tick(2);
    chk("drain_busy", busy, 1);
    chk("drain_no_frame_done_yet", fd_count, 0);
    issue(2'b11, 21'h0);
    rdy_mode = 2;
    wait_ack(60, lat);
    ack_cyc = cyc;
    chk("drain_cmd_acked", lat > 0, 1);
    tick(4);
    rdy_mode = 0;
    wr_ready = 1'b0;
    chk("drain_frame_done_once", fd_count, 1);
    chk("drain_frame_done_cycle", fd_cyc, last_acc_cyc + 1);
    chk("drain_ack_after_frame_done", ack_cyc > fd_cyc, 1);
    chk("drain_all_written", exp_q.size(), 0);
    do_reset();

    // Protocol error
    for (int i = 0; i < 5; i++) begin
      issue(2'b01, 21'($urandom_range(0, 65535)));
      wait_ack(6, lat);
    end
    chk("perr_before", proto_err, 0);
    tog = ~tog;
    pixin[23] = tog;
    tick(2);
    tog = ~tog;
    pixin[23] = tog;
    tick(2);
    chk("perr_set", proto_err, 1);
    tick(10);
    chk("perr_sticky", proto_err, 1);
    do_reset();
    chk("perr_cleared", proto_err, 0);

    // Reset with queued entries
    for (int i = 0; i < 3; i++) begin
      issue(2'b01, 21'($urandom_range(0, 65535)));
      wait_ack(6, lat);
    end
    chk("queued_wr_req", wr_req, 1);
    do_reset();
    chk("midrst_wr_req", wr_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pix_ack", pix_ack, 0);
    ws = writes_seen;
    wr_ready = 1'b1;
    tick(10);
    chk("midrst_no_writes", writes_seen, ws);

    // Randomized traffic
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r < 2) op = 2'b00;
      else if (r == 2) op = 2'b11;
      else if (r == 3) op = 2'b10;
      else op = 2'b01;
      if (op == 2'b00 && r == 0) issue(op, 21'h0FFFFE);
      else issue(op, 21'($urandom_range(0, 21'h0FFFFF)));
      wait_ack(80, lat);
      chk("rand_ack", lat > 0, 1);
      if (op == 2'b10) wait_idle("rand_frame_idle", 100);
    end
    rdy_mode = 0;
    wr_ready = 1'b1;
    wait_idle("rand_drained", 200);
    chk("rand_proto_err", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
